// File: rtl/uart_clk_pkg.sv
// Shared definitions for the UART clock path: default ratio width, the
// bypass threshold, and the ratio encodings agreed with the upstream decoder.
package uart_clk_pkg;

  localparam int RATIO_WD_DEF   = 8;
  localparam int DIV_BYPASS_MIN = 2;

  typedef enum logic [2:0] {
    RATIO_BYPASS = 3'd1,
    RATIO_DIV2   = 3'd2,
    RATIO_DIV4   = 3'd4
  } ratio_enc_e;

endpackage

// File: rtl/clk_div_bypass_mux.sv
// Final selection between the reference clock and the divided clock.
// Kept as its own module so it can be swapped for a library clock-mux cell.
module clk_div_bypass_mux (
  input  logic ref_clk,
  input  logic div_clk,
  input  logic sel_div,
  output logic mux_clk
);

  assign mux_clk = sel_div ? div_clk : ref_clk;

endmodule

// File: rtl/clk_div_int.sv
// Integer clock divider. Even ratios give 50 % duty; odd ratios are exact
// only when CLK_DIV_ODD_EN is defined, otherwise bit 0 of the ratio is
// dropped. Ratio updates are taken only at period boundaries or when
// leaving bypass, so the divided clock never produces a short pulse.
import uart_clk_pkg::*;

module clk_div_int #(
  parameter int RATIO_WD = RATIO_WD_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                I_CLK_EN,
  input  logic [RATIO_WD-1:0] I_DIV_RATIO,
  output logic                O_DIV_CLK
);

  localparam logic [RATIO_WD-1:0] ONE     = RATIO_WD'(1);
  localparam logic [RATIO_WD-1:0] BYP_MIN = RATIO_WD'(DIV_BYPASS_MIN);

  logic [RATIO_WD-1:0] ratio_q;
  logic [RATIO_WD-1:0] cnt;
  logic                div_q;
  logic                run_q;

  logic                active;
  logic [RATIO_WD-1:0] next_ratio;
  logic [RATIO_WD-1:0] low_term;
  logic [RATIO_WD-1:0] high_term;

  assign active = I_CLK_EN && (I_DIV_RATIO >= BYP_MIN);

`ifdef CLK_DIV_ODD_EN
  // Odd ratios: low phase takes the extra cycle (ceil), high phase floor.
  assign next_ratio = I_DIV_RATIO;
  assign low_term   = (ratio_q >> 1) + {{(RATIO_WD-1){1'b0}}, ratio_q[0]} - ONE;
  assign high_term  = (ratio_q >> 1) - ONE;
`else
  // Even-only: ratio rounded down to even, both phases are N/2 long.
  assign next_ratio = I_DIV_RATIO & ~ONE;
  assign low_term   = (ratio_q >> 1) - ONE;
  assign high_term  = low_term;
`endif

  // Phase counter, divided clock flop and boundary-aligned ratio sampling.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_q   <= 1'b0;
      div_q   <= 1'b0;
      cnt     <= '0;
      ratio_q <= ONE;
    end else if (!active) begin
      // Bypass wins immediately, even mid-period or on a boundary.
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (!run_q) begin
      run_q   <= 1'b1;
      ratio_q <= next_ratio;
      cnt     <= '0;
      div_q   <= 1'b0;
    end else if (!div_q) begin
      if (cnt == low_term) begin
        div_q <= 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end else begin
      if (cnt == high_term) begin
        // End of high phase is the period boundary: pick up a new ratio.
        div_q   <= 1'b0;
        cnt     <= '0;
        ratio_q <= next_ratio;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  clk_div_bypass_mux u_mux (
    .ref_clk (CLK),
    .div_clk (div_q),
    .sel_div (run_q),
    .mux_clk (O_DIV_CLK)
  );

endmodule

// File: tb/tb_clk_div_int.sv
// Bench for clk_div_int: expected output waveform per reference cycle is
// queued when stimulus is applied and checked at both clock halves.
module tb_clk_div_int;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ratio;
  logic       div_clk;

  int checks = 0;
  int errors = 0;
  string cur_name = "reset";

  // Each entry: {value after rising edge, value after falling edge}
  logic [1:0] exp_q[$];

  typedef struct {
    logic       en;
    logic [7:0] ratio;
    int         lo;   // 0 means bypass expected
    int         hi;
    string      name;
  } vec_t;

  vec_t vecs[9];

  clk_div_int #(.RATIO_WD(8)) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .I_CLK_EN    (en),
    .I_DIV_RATIO (ratio),
    .O_DIV_CLK   (div_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic got, input logic want, input string what);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s/%s t=%0t got %b want %b", cur_name, what, $time, got, want);
    end
  endtask

  task automatic push_div(input int lo, input int hi, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < lo; i++) exp_q.push_back(2'b00);
      for (int i = 0; i < hi; i++) exp_q.push_back(2'b11);
    end
  endtask

  task automatic push_byp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b10);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s/drain timeout left %0d want 0", cur_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: compare queued expectations at both halves of each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        chk(div_clk, exp_q[0][1], "rise_half");
        @(negedge clk);
        #1;
        chk(div_clk, exp_q[0][0], "fall_half");
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 8'd4,   2,   2,   "r4"};
`ifdef CLK_DIV_ODD_EN
    vecs[1] = '{1'b1, 8'd5,   3,   2,   "r5"};
    vecs[2] = '{1'b1, 8'd3,   2,   1,   "r3"};
    vecs[3] = '{1'b1, 8'd255, 128, 127, "r255"};
`else
    vecs[1] = '{1'b1, 8'd5,   2,   2,   "r5"};
    vecs[2] = '{1'b1, 8'd3,   1,   1,   "r3"};
    vecs[3] = '{1'b1, 8'd255, 127, 127, "r255"};
`endif
    vecs[4] = '{1'b1, 8'd2,   1,   1,   "r2"};
    vecs[5] = '{1'b1, 8'd8,   4,   4,   "r8"};
    vecs[6] = '{1'b0, 8'd4,   0,   0,   "en0"};
    vecs[7] = '{1'b1, 8'd0,   0,   0,   "r0"};
    vecs[8] = '{1'b1, 8'd1,   0,   0,   "r1"};

    rst_n = 1'b0;
    en    = 1'b0;
    ratio = 8'd0;
    push_byp(3);
    drain();
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      cur_name = vecs[v].name;
      en = 1'b0;
      push_byp(1);
      drain();
      en    = vecs[v].en;
      ratio = vecs[v].ratio;
      if (vecs[v].lo == 0) push_byp(6);
      else push_div(vecs[v].lo, vecs[v].hi, 2);
      drain();
    end

    // Ratio 4 -> 2 one cycle into the first low phase.
    cur_name = "chg4to2";
    en = 1'b0; push_byp(1); drain();
    en = 1'b1; ratio = 8'd4;
    push_div(2, 2, 1);
    push_div(1, 1, 3);
    @(negedge clk); #2;
    ratio = 8'd2;
    drain();

    // Enable dropped in the high phase, then re-enabled at ratio 8.
    cur_name = "en_drop_high";
    en = 1'b0; push_byp(1); drain();
    en = 1'b1; ratio = 8'd4;
    push_div(2, 1, 1);
    drain();
    en = 1'b0;
    push_byp(3);
    drain();
    cur_name = "reen_r8";
    en = 1'b1; ratio = 8'd8;
    push_div(4, 4, 2);
    drain();

    // Enable falls exactly on a period boundary: bypass must win.
    cur_name = "en_drop_boundary";
    en = 1'b0; push_byp(1); drain();
    en = 1'b1; ratio = 8'd2;
    push_div(1, 1, 1);
    drain();
    en = 1'b0;
    push_byp(2);
    drain();

    // Reset pulsed in the high phase at ratio 8, enable held throughout.
    cur_name = "rst_mid";
    en = 1'b1; ratio = 8'd8;
    push_div(4, 2, 1);
    drain();
    rst_n = 1'b0;
    #1;
    chk(div_clk, 1'b0, "async_bypass");
    push_byp(2);
    drain();
    cur_name = "rst_resume";
    rst_n = 1'b1;
    push_div(4, 4, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_int.md
# clk_div_int

Integer clock divider sitting directly downstream of the prescale-to-ratio decoder in the UART clock path. It takes the decoded division ratio and produces the divided UART RX/TX clock. Even ratios give a 50 % duty cycle, and odd ratios give a one-cycle asymmetry. Ratio changes apply only at output-period boundaries, so the output never glitches.

## Interface
- RATIO_WD, 8, width of the division ratio input
- CLK  in  1  reference clock (UART_CLK)
- RST  in  1  reset, asynchronous, active-low
- I_CLK_EN  in  1  divider enable; low selects bypass
- I_DIV_RATIO  in  RATIO_WD  requested division ratio N (from ratio decoder)
- O_DIV_CLK  out  1  divided clock

## Operation
- Internal registers:
  - ratio_q (RATIO_WD), the active ratio
  - cnt (RATIO_WD), the phase cycle counter
  - div_q, the divided clock flop
  - run_q, divider active
- active = I_CLK_EN && (I_DIV_RATIO >= 2).
- O_DIV_CLK = run_q ? div_q : CLK. Bypass covers ratio 0, ratio 1, and enable low.
- Phase lengths for active ratio N:
  - low phase L = ceil(N/2)
  - high phase H = floor(N/2)
  - period = N cycles
- Sequence when active:
  - Start in low phase with div_q=0 and cnt=0.
  - cnt increments each CLK rising edge.
  - When cnt reaches L-1 (low phase) or H-1 (high phase), div_q toggles and cnt clears.
- Ratio sampling: ratio_q ← I_DIV_RATIO only at a period boundary (end of high phase) or when leaving bypass. Changes mid-period are ignored until the boundary.
- Leaving bypass (active rises): on the same edge, run_q=1, ratio_q loaded, cnt=0, div_q=0.
- Entering bypass (active falls): run_q=0, div_q=0, cnt=0 on the next edge. This applies mid-period; there is no wait for the boundary.
- Counter arithmetic is RATIO_WD wide and unsigned; it never wraps because the terminal count is ≤ 2^(RATIO_WD-1).

## Timing
- Reset values:
  - run_q=0, div_q=0, cnt=0, ratio_q=1
  - O_DIV_CLK therefore follows CLK (bypass) during and directly after reset.
- Latency: the first O_DIV_CLK rising edge comes L CLK edges after the edge that leaves bypass.
- Ratio change takes effect in the first full period after the current period completes. There is no partial period.
- Reset asserted mid-operation forces bypass immediately (asynchronous). Resumption follows the leave-bypass rule.
- Simultaneous period boundary and enable fall: bypass wins.

## Configuration
- CLK_DIV_ODD_EN:
  - Defined: odd ratios are supported exactly, with L=(N+1)/2 and H=(N-1)/2.
  - Undefined: I_DIV_RATIO[0] is ignored for N ≥ 2, so N is treated as N & ~1 (5→4, 3→2). All outputs are 50 % duty, and the odd-phase comparison logic is removed.
- Ratio 1 bypass is unaffected either way.

## Structure
- Shared package (uart_clk_pkg):
  - RATIO_WD default
  - DIV_BYPASS_MIN = 2
  - ratio encodings 1/2/4 shared with the upstream decoder
- One natural sub-module: clk_div_bypass_mux, the final glitch-safe selection between CLK and div_q. It is kept separate so synthesis can map it to a library clock-mux cell.
- Counter, phase control and ratio sampling stay in clk_div_int.

## Test plan
- Enable=1, ratio=4 → O_DIV_CLK period 4 CLK; low 2, high 2; first rise 2 edges after enable.
- Enable=1, ratio=5 with CLK_DIV_ODD_EN → low 3, high 2, period 5. Without the macro → period 4, low 2, high 2.
- Ratio 0 or 1, or enable=0 → O_DIV_CLK identical to CLK, with no extra edges.
- Ratio changed 4→2 one cycle into a low phase → current period stays 4 cycles, next periods 2 cycles, no short pulse.
- Enable dropped mid high phase → O_DIV_CLK returns to CLK on the next edge. Re-enabled with ratio 8 → 4 low, 4 high.
- RST pulsed low mid period at ratio 8 → bypass immediately. After release with enable held → restarts in low phase, 4 low, 4 high.
